// File: rtl/accum_drain_ctrl_if.sv
// Accumulator read port plus row output stream of the drain controller.
// master = drain controller side, slave = RAM / unified-buffer writer side.
interface accum_drain_ctrl_if #(
    parameter int DW     = 1024,
    parameter int ADDR_W = 7
);
    logic              accum_rd_en_o;
    logic [ADDR_W-1:0] accum_rd_addr_o;
    logic [DW-1:0]     accum_rd_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DW-1:0]     out_data_o;
    logic              out_last_o;

    modport master (
        output accum_rd_en_o, accum_rd_addr_o, out_valid_o, out_data_o, out_last_o,
        input  accum_rd_data_i, out_ready_i
    );
    modport slave (
        input  accum_rd_en_o, accum_rd_addr_o, out_valid_o, out_data_o, out_last_o,
        output accum_rd_data_i, out_ready_i
    );
endinterface

// File: rtl/accum_drain_ctrl.sv
// Drains the accumulator RAM row by row into a valid/ready stream once a job ends,
// sharing the single read port with the compute sequencer (compute always wins).
module accum_drain_ctrl #(
    parameter int MUL_SIZE = 32,
    parameter int ACC_W    = 32,
    parameter int ADDR_W   = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [8:0]        H_DIM_i,
    input  logic [8:0]        W_DIM_i,
    input  logic              compute_rd_req_i,
    input  logic [ADDR_W-1:0] compute_rd_addr_i,
    accum_drain_ctrl_if.master bus,
    output logic              busy_o,
    output logic              done_o,
    output logic              cfg_err_o
);
    localparam int          DW       = MUL_SIZE * ACC_W;
    localparam logic [15:0] ADDR_MAX = 16'((1 << ADDR_W) - 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DRAIN, S_FLUSH, S_DONE} state_t;

    state_t r_state, w_next;

    logic [8:0]        r_h_dim;
    logic [4:0]        r_tiles;
    logic [15:0]       r_stride;
    logic [8:0]        r_row;
    logic [4:0]        r_tile;
    logic [15:0]       r_base;
    logic              r_cfg_err;
    logic              r_inflight;
    logic              r_inflight_last;
    logic [DW:0]       r_mem [2];
    logic              r_wp, r_rp;
    logic [1:0]        r_cnt;

    logic              w_busy, w_done, w_in_check, w_in_drain;
    logic [15:0]       w_span;
    logic              w_ovf;
    logic [ADDR_W-1:0] w_drain_addr;
    logic              w_last_addr;
    logic              w_pop;
    logic [2:0]        w_occ;
    logic              w_drain_rd;
    logic              w_drained;
    logic [DW:0]       w_head;

    // Highest address the job touches, evaluated wide so overflow is visible.
    assign w_span       = 16'(r_tiles - 5'd1) * r_stride + 16'(r_h_dim);
    assign w_ovf        = (w_span > ADDR_MAX);
    assign w_drain_addr = ADDR_W'(r_base + 16'(r_row));
    assign w_last_addr  = (r_row == r_h_dim) && (r_tile == r_tiles - 5'd1);

    assign w_head = r_mem[r_rp];
    assign w_pop  = (r_cnt != 2'd0) && bus.out_ready_i;

    // Credit counts the slot freed by this cycle's pop so a free-flowing stream
    // sustains one read per cycle; occupancy + in-flight still never exceeds 2.
    assign w_occ      = 3'(r_cnt) - 3'(w_pop) + 3'(r_inflight);
    assign w_drain_rd = w_in_drain && !compute_rd_req_i && (w_occ < 3'd2);

    // Lets DONE land the cycle right after the final beat is popped.
    assign w_drained = !r_inflight && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_next = S_CHECK;
            S_CHECK: w_next = w_ovf ? S_DONE : S_DRAIN;
            S_DRAIN: if (w_drain_rd && w_last_addr) w_next = S_FLUSH;
            S_FLUSH: if (w_drained) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = (r_state != S_IDLE);
        w_done     = (r_state == S_DONE);
        w_in_check = (r_state == S_CHECK);
        w_in_drain = (r_state == S_DRAIN);
    end

    // Geometry latch and the row-major address walk; the walk only advances
    // on an issued read, so a slot lost to compute retries the same address.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_h_dim   <= '0;
            r_tiles   <= '0;
            r_stride  <= '0;
            r_row     <= '0;
            r_tile    <= '0;
            r_base    <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start_i) begin
                r_h_dim   <= H_DIM_i;
                r_tiles   <= 5'((16'(W_DIM_i) + 16'd32) >> 5);
                r_stride  <= (16'(H_DIM_i) + 16'd32) & 16'hFFE0;
                r_row     <= '0;
                r_tile    <= '0;
                r_base    <= '0;
                r_cfg_err <= 1'b0;
            end
            if (w_in_check && w_ovf) r_cfg_err <= 1'b1;
            if (w_drain_rd) begin
                if (r_row == r_h_dim) begin
                    r_row  <= '0;
                    r_tile <= r_tile + 5'd1;
                    r_base <= r_base + r_stride;
                end else begin
                    r_row <= r_row + 9'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_drain_rd;
            r_inflight_last <= w_drain_rd && w_last_addr;
        end
    end

    // Two-entry output FIFO; each entry carries its row plus the last-beat tag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 2; i++) r_mem[i] <= '0;
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_mem[r_wp] <= {r_inflight_last, bus.accum_rd_data_i};
                r_wp        <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_cnt <= r_cnt + 2'(r_inflight) - 2'(w_pop);
        end
    end

    always_comb begin
        bus.accum_rd_en_o   = compute_rd_req_i | w_drain_rd;
        bus.accum_rd_addr_o = '0;
        if (compute_rd_req_i) bus.accum_rd_addr_o = compute_rd_addr_i;
        else if (w_drain_rd)  bus.accum_rd_addr_o = w_drain_addr;
    end

    assign bus.out_valid_o = (r_cnt != 2'd0);
    assign bus.out_data_o  = w_head[DW-1:0];
    assign bus.out_last_o  = bus.out_valid_o && w_head[DW];

    assign busy_o    = w_busy;
    assign done_o    = w_done;
    assign cfg_err_o = r_cfg_err;
endmodule

// File: tb/tb_accum_drain_ctrl.sv
// Bench for accum_drain_ctrl: directed job table, mid-drain reset, random jobs,
// all judged against an address-list model built from the job geometry.
module tb_accum_drain_ctrl;
    localparam int MS = 32, AW_ACC = 32, AW = 7;
    localparam int DW = MS * AW_ACC;

    logic clk = 1'b0, rst_i = 1'b0, start_i = 1'b0, compute_rd_req_i = 1'b0;
    logic [8:0] H_DIM_i = '0, W_DIM_i = '0;
    logic [AW-1:0] compute_rd_addr_i = '0;
    logic busy_o, done_o, cfg_err_o;

    accum_drain_ctrl_if #(.DW(DW), .ADDR_W(AW)) bus();

    accum_drain_ctrl #(.MUL_SIZE(MS), .ACC_W(AW_ACC), .ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .H_DIM_i(H_DIM_i), .W_DIM_i(W_DIM_i),
        .compute_rd_req_i(compute_rd_req_i), .compute_rd_addr_i(compute_rd_addr_i),
        .bus(bus), .busy_o(busy_o), .done_o(done_o), .cfg_err_o(cfg_err_o)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    int unsigned salt = 0;
    int exp_q[$];
    bit mon_en = 0;
    int rd_idx, beat_idx, done_cnt, done_cyc, first_valid_cyc, last_beat_cyc;
    bit hold_prev;
    logic [DW-1:0] prev_data, last_beat_data;
    logic prev_last;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mkdata(input int a, input int unsigned s);
        logic [DW-1:0] d;
        for (int i = 0; i < MS; i++)
            d[i*AW_ACC +: AW_ACC] = (32'(a) * 32'h0100_0193) ^ (32'(i) << 20) ^ s;
        return d;
    endfunction

    // RAM: read data appears the cycle after the enable, for either requester.
    initial bus.accum_rd_data_i = '0;
    always @(posedge clk)
        if (bus.accum_rd_en_o) bus.accum_rd_data_i <= mkdata(int'(bus.accum_rd_addr_o), salt);

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic chk_wide(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        logic [63:0] g, e;
        checks++;
        if (got !== exp) begin
            errors++;
            g = got[63:0];
            e = exp[63:0];
            $display("FAIL %s: got ..%h expected ..%h (cycle %0d)", nm, g, e, cyc);
        end
    endtask

    // Model: list every address the job must read, in order; 1 = geometry overflows.
    function automatic bit build_model(input int h, input int w);
        int tiles, stride;
        exp_q.delete();
        tiles  = (w / 32) + 1;
        stride = ((h / 32) + 1) * 32;
        if ((tiles - 1) * stride + h > (1 << AW) - 1) return 1'b1;
        for (int t = 0; t < tiles; t++)
            for (int r = 0; r <= h; r++) exp_q.push_back(t * stride + r);
        return 1'b0;
    endfunction

    always @(negedge clk) begin : monitor
        logic pop;
        if (mon_en) begin
            pop = bus.out_valid_o && bus.out_ready_i;
            if (compute_rd_req_i) begin
                chk("cmp_en", 64'(bus.accum_rd_en_o), 64'd1);
                chk("cmp_addr", 64'(bus.accum_rd_addr_o), 64'(compute_rd_addr_i));
            end else if (bus.accum_rd_en_o) begin
                if (rd_idx < exp_q.size()) chk("rd_addr", 64'(bus.accum_rd_addr_o), 64'(exp_q[rd_idx]));
                else chk("extra_rd", 64'(rd_idx), 64'(exp_q.size()));
                rd_idx++;
                chk("credit", 64'((rd_idx - beat_idx - int'(pop)) <= 2), 64'd1);
            end else begin
                chk("idle_addr", 64'(bus.accum_rd_addr_o), 64'd0);
            end
            if (hold_prev) begin
                chk("hold_valid", 64'(bus.out_valid_o), 64'd1);
                chk_wide("hold_data", bus.out_data_o, prev_data);
                chk("hold_last", 64'(bus.out_last_o), 64'(prev_last));
            end
            if (bus.out_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (pop) begin
                if (beat_idx < exp_q.size()) begin
                    chk_wide("beat_data", bus.out_data_o, mkdata(exp_q[beat_idx], salt));
                    chk("beat_last", 64'(bus.out_last_o), 64'(beat_idx == exp_q.size() - 1));
                end else chk("extra_beat", 64'(beat_idx), 64'(exp_q.size()));
                beat_idx++;
                last_beat_cyc  = cyc;
                last_beat_data = bus.out_data_o;
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            hold_prev = bus.out_valid_o && !bus.out_ready_i;
            prev_data = bus.out_data_o;
            prev_last = bus.out_last_o;
        end
    end

    task automatic arm_monitor();
        salt = $urandom;
        rd_idx = 0; beat_idx = 0; done_cnt = 0; done_cyc = -1;
        first_valid_cyc = -1; last_beat_cyc = -1; hold_prev = 0;
        mon_en = 1;
    endtask

    // rm: 0 ready high, 1 ready low for job cycles 5..14, 2 random.
    // cm: 0 no compute, 1 compute on odd cycles at 0x55, 2 random compute.
    task automatic run_job(input int h, input int w, input int rm, input int cm);
        int s;
        bit err;
        err = build_model(h, w);
        arm_monitor();
        @(posedge clk); #1;
        s = cyc;
        H_DIM_i = 9'(h);
        W_DIM_i = 9'(w);
        for (int k = 0; k < 4000; k++) begin
            if (done_cnt > 0 && cyc > done_cyc) break;
            start_i = (k == 0);
            case (rm)
                0: bus.out_ready_i = 1'b1;
                1: bus.out_ready_i = !(k >= 5 && k <= 14);
                default: bus.out_ready_i = ($urandom_range(0, 3) != 0);
            endcase
            case (cm)
                0: compute_rd_req_i = 1'b0;
                1: begin compute_rd_req_i = k[0]; compute_rd_addr_i = 7'h55; end
                default: begin
                    compute_rd_req_i  = ($urandom_range(0, 3) == 0);
                    compute_rd_addr_i = AW'($urandom_range(0, 127));
                end
            endcase
            if (k == 1) begin
                chk("cfg_clr", 64'(cfg_err_o), 64'd0);
                chk("busy_run", 64'(busy_o), 64'd1);
            end
            @(posedge clk); #1;
        end
        start_i = 1'b0; bus.out_ready_i = 1'b1; compute_rd_req_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 0;
        chk("done_seen", 64'(done_cnt), 64'd1);
        chk("cfg_err", 64'(cfg_err_o), 64'(err));
        chk("rd_count", 64'(rd_idx), 64'(exp_q.size()));
        chk("beat_count", 64'(beat_idx), 64'(exp_q.size()));
        chk("done_time", 64'(done_cyc), err ? 64'(s + 2) : 64'(last_beat_cyc + 1));
        chk("busy_idle", 64'(busy_o), 64'd0);
        if (rm == 0 && cm == 0 && !err) chk("first_valid", 64'(first_valid_cyc), 64'(s + 4));
    endtask

    typedef struct {
        int h; int w; int rm; int cm;
        bit err; int beats; int last_addr;
    } vec_t;

    initial begin
        vec_t tbl[11];
        int h, w;
        tbl[0]  = '{31, 31, 0, 0, 1'b0, 32, 31};
        tbl[1]  = '{40, 63, 0, 0, 1'b0, 82, 104};
        tbl[2]  = '{31, 31, 1, 0, 1'b0, 32, 31};
        tbl[3]  = '{31, 31, 0, 1, 1'b0, 32, 31};
        tbl[4]  = '{200, 200, 0, 0, 1'b1, 0, 0};
        tbl[5]  = '{31, 31, 0, 0, 1'b0, 32, 31};
        tbl[6]  = '{0, 0, 0, 0, 1'b0, 1, 0};
        tbl[7]  = '{127, 0, 0, 0, 1'b0, 128, 127};
        tbl[8]  = '{63, 32, 2, 2, 1'b0, 128, 127};
        tbl[9]  = '{64, 32, 0, 0, 1'b1, 0, 0};
        tbl[10] = '{0, 32, 0, 0, 1'b0, 2, 32};

        bus.out_ready_i = 1'b1;
        #3;
        chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_cfg", 64'(cfg_err_o), 64'd0);
        chk("rst_rden", 64'(bus.accum_rd_en_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_job(tbl[i].h, tbl[i].w, tbl[i].rm, tbl[i].cm);
            chk("tbl_err", 64'(cfg_err_o), 64'(tbl[i].err));
            chk("tbl_beats", 64'(beat_idx), 64'(tbl[i].beats));
            if (tbl[i].beats > 0) chk_wide("tbl_last", last_beat_data, mkdata(tbl[i].last_addr, salt));
        end

        // Reset in the middle of a drain, then a clean re-run.
        void'(build_model(31, 31));
        arm_monitor();
        @(posedge clk); #1;
        H_DIM_i = 9'd31; W_DIM_i = 9'd31; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int k = 0; k < 300 && beat_idx < 10; k++) begin
            @(posedge clk); #1;
        end
        chk("rst_reach", 64'(beat_idx >= 10), 64'd1);
        mon_en = 0;
        rst_i = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("mid_rst_last", 64'(bus.out_last_o), 64'd0);
        chk("mid_rst_data", 64'(|bus.out_data_o), 64'd0);
        chk("mid_rst_rden", 64'(bus.accum_rd_en_o), 64'd0);
        chk("mid_rst_addr", 64'(bus.accum_rd_addr_o), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_done", 64'(done_o), 64'd0);
        chk("mid_rst_cfg", 64'(cfg_err_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b1;
        run_job(31, 31, 0, 0);

        for (int j = 0; j < 8; j++) begin
            h = $urandom_range(0, 130);
            w = $urandom_range(0, 100);
            run_job(h, w, 2, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/accum_drain_ctrl.md
Name: accum_drain_ctrl

Overview:
- Sequences readout of the output accumulator memory once a matmul job completes.
- Streams each accumulator row to the unified-buffer writer over a valid/ready interface.
- Shares the single accumulator read port with the compute sequencer; the compute side always has priority.
- Sits between control_unit (start from its done_o, read requests from its read_accumulator_o) and the accumulator RAM.

Parameters:
- MUL_SIZE, 32, systolic array dimension; elements per accumulator row.
- ACC_W, 32, bits per accumulator element.
- ADDR_W, 7, accumulator address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; reset is asynchronous and active-low.
- start_i  in  1  single-cycle drain request.
- H_DIM_i  in  9  activation rows minus 1; sampled on accepted start.
- W_DIM_i  in  9  output columns minus 1; sampled on accepted start.
- compute_rd_req_i  in  1  compute sequencer requests the read port.
- compute_rd_addr_i  in  ADDR_W  compute read address.
- accum_rd_en_o  out  1  accumulator read enable.
- accum_rd_addr_o  out  ADDR_W  accumulator read address.
- accum_rd_data_i  in  MUL_SIZE*ACC_W  read data, valid 1 cycle after accum_rd_en_o.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream accepts the beat.
- out_data_o  out  MUL_SIZE*ACC_W  accumulator row.
- out_last_o  out  1  final beat of the job.
- busy_o  out  1  high whenever state is not IDLE.
- done_o  out  1  one-cycle completion pulse.
- cfg_err_o  out  1  sticky flag: configuration overflows the address space; cleared on the next accepted start.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs go to 0; state goes to IDLE; counters and the output FIFO clear; any in-flight read is discarded.
  - Applies at any point, including mid-drain.
- Job geometry, latched at start:
  - rows = H_DIM_i+1
  - tiles = (W_DIM_i>>5)+1
  - stride = ((H_DIM_i>>5)+1)<<5
  - addr = tile*stride + row, computed at 16 bits and truncated to ADDR_W only after the range check.
- FSM states:
  - IDLE: start_i goes to CHECK. start_i in any other state is ignored.
  - CHECK (1 cycle):
    - If (tiles-1)*stride + H_DIM_i > 2^ADDR_W - 1: set cfg_err_o and go to DONE.
    - Otherwise go to DRAIN.
  - DRAIN: issue reads row-major (row 0..H_DIM_i within each tile, then tile+1). After the last address issues, go to FLUSH.
  - FLUSH: wait until no read is in flight and the FIFO is empty, then go to DONE.
  - DONE (1 cycle): done_o=1, then go to IDLE.
- Port arbitration (combinational mux, registered outputs are not used):
  - When compute_rd_req_i=1: accum_rd_en_o=1 and accum_rd_addr_o=compute_rd_addr_i, in every state.
  - A drain read issues only when state=DRAIN, compute_rd_req_i=0, and FIFO occupancy + in-flight < 2.
  - When neither side reads: accum_rd_en_o=0 and accum_rd_addr_o=0.
- Read pipeline:
  - A 1-bit in-flight flag marks a drain read issued last cycle; its data is pushed into a 2-entry FIFO on the next cycle.
  - Compute reads never push into the FIFO.
  - The credit rule above guarantees the FIFO never overflows.
- Output stream:
  - out_valid_o = FIFO not empty; out_data_o is the FIFO head.
  - A beat transfers when out_valid_o && out_ready_i.
  - out_data_o and out_last_o are held stable while out_valid_o=1 and out_ready_i=0.
  - out_last_o=1 only on the beat carrying the final row of the final tile.
  - Beat order equals address order.
  - Total beats = rows*tiles.
- Timing:
  - Minimum latency from start_i to the first out_valid_o is 3 cycles (CHECK, issue, capture).
  - With out_ready_i=1 and no compute requests, throughput is 1 beat per cycle.
  - done_o pulses the cycle after the last beat transfers.
- Simultaneous events:
  - compute_rd_req_i arriving in the same cycle as a drain-eligible slot: compute wins, the drain address is held and retried next cycle.
  - Push and pop in the same cycle keep occupancy unchanged.

Test Plan:
- H_DIM=31, W_DIM=31, out_ready_i=1 → 32 reads at addresses 0..31, out_last_o on beat 32, done_o 1 cycle later, cfg_err_o=0.
- H_DIM=40, W_DIM=63 → addresses 0..40 then 64..104, 82 beats in order, out_last_o only on the address-104 beat.
- H_DIM=31, W_DIM=31, out_ready_i held low for cycles 5..14 → occupancy + in-flight ≤ 2 throughout, no read issued while stalled, all 32 rows delivered exactly once in order.
- Same job with compute_rd_req_i=1 on alternate cycles, addr 0x55 → those cycles show accum_rd_addr_o=0x55, drain reads fill the gaps, stream data unchanged, done_o still fires.
- H_DIM=200, W_DIM=200, ADDR_W=7 → cfg_err_o=1, zero drain reads, done_o at start+2; next valid start clears cfg_err_o.
- Reset asserted after beat 10 of a 32-beat job → all outputs 0 immediately; after release, a new start drains all 32 rows from address 0 with no stale beat.
